// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code receive path.
// Functions take the code zero-extended to QMAX bits plus its true width n,
// so every Johnson-domain block can reuse them regardless of its own N.
package johnson_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int JOHNSON_N = 4;
  localparam int CNT_W     = $clog2(2 * JOHNSON_N);
  localparam int RUN_W     = 4;
  localparam int QMAX      = 32;

  // Legal codes are zeros-over-ones (msb 0) or ones-over-zeros (msb 1).
  function automatic logic johnson_legal(input logic [QMAX-1:0] q, input int n);
    logic [QMAX-1:0] mask;
    logic [QMAX-1:0] body;
    logic [QMAX-1:0] top;
    mask = (n >= QMAX) ? '1 : ((QMAX'(1) << n) - QMAX'(1));
    top  = q >> (n - 1);
    body = top[0] ? (~q & mask) : (q & mask);
    return ((q & ~mask) == '0) && ((body & (body + QMAX'(1))) == '0);
  endfunction

  // popcount for msb 0, 2n - popcount for msb 1; meaningful only on legal codes.
  function automatic int johnson_to_bin(input logic [QMAX-1:0] q, input int n);
    logic [QMAX-1:0] w;
    logic [QMAX-1:0] top;
    int pop;
    w   = q;
    pop = 0;
    for (int i = 0; i < QMAX; i++) begin
      if (i < n) pop += int'(w[0]);
      w = w >> 1;
    end
    top = q >> (n - 1);
    return top[0] ? (2 * n - pop) : pop;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code legality check and binary decode.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(2 * N)
) (
  input  logic [N-1:0]  q,
  output logic          legal,
  output logic [CW-1:0] bin
);

  logic [QMAX-1:0] qx;

  // Widen once, then reuse the shared package helpers.
  always_comb begin
    qx    = QMAX'(q);
    legal = johnson_legal(qx, N);
    bin   = CW'(johnson_to_bin(qx, N));
  end

endmodule

// File: rtl/johnson_decoder_monitor.sv
// Johnson code receive monitor: legality, decode, step check, lock FSM,
// wrap pulse and saturating error count. Define JOHNSON_DOWN_EN to accept
// -1 steps as legal and add the dir output.
//
// Handshake: sample_en qualifies q_in for exactly the cycle it is high; there
// is no back-pressure. valid/illegal/bad_step/wrap are registered one-cycle
// pulses on the edge that samples sample_en=1 and are 0 in every other cycle.
module johnson_decoder_monitor
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [N-1:0]            q_in,
  input  logic                    sample_en,
  input  logic                    err_clr,
  output logic [$clog2(2*N)-1:0]  count,
  output logic                    valid,
  output logic                    illegal,
  output logic                    bad_step,
  output logic                    wrap,
  output logic                    locked,
  output logic [ERR_W-1:0]        err_cnt,
`ifdef JOHNSON_DOWN_EN
  output logic                    dir,
`endif
  output state_t                  fsm_state
);

  localparam int CW     = $clog2(2 * N);
  localparam int DW     = CW + 1;
  localparam int STATES = 2 * N;

  logic             dec_legal;
  logic [CW-1:0]    dec_bin;
  logic [DW-1:0]    delta;
  logic             is_hold, is_up;
  logic             good, err_ev;
  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             have_prev, have_prev_d;
  logic [CW-1:0]    count_d;
  logic             valid_d, illegal_d, bad_d, wrap_d;
  logic [ERR_W-1:0] err_d;
`ifdef JOHNSON_DOWN_EN
  logic             is_down;
  logic             dir_d;
`endif

  johnson_code_decode #(.N(N), .CW(CW)) u_decode (
    .q     (q_in),
    .legal (dec_legal),
    .bin   (dec_bin)
  );

  // Step distance from the previous legal value, modulo 2N (count holds prev).
  always_comb begin
    if (dec_bin >= count) delta = {1'b0, dec_bin} - {1'b0, count};
    else                  delta = {1'b0, dec_bin} + DW'(STATES) - {1'b0, count};
    is_hold = (delta == '0);
    is_up   = (delta == DW'(1));
`ifdef JOHNSON_DOWN_EN
    is_down = (delta == DW'(STATES - 1));
`endif
  end

  // Sample classification, lock FSM next state and error counter next value.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    have_prev_d = have_prev;
    count_d     = count;
    valid_d     = 1'b0;
    illegal_d   = 1'b0;
    bad_d       = 1'b0;
    wrap_d      = 1'b0;
    good        = 1'b0;
    err_ev      = 1'b0;
    err_d       = err_cnt;
`ifdef JOHNSON_DOWN_EN
    dir_d       = dir;
`endif

    if (sample_en) begin
      if (!dec_legal) begin
        illegal_d   = 1'b1;
        have_prev_d = 1'b0;
        err_ev      = 1'b1;
      end else begin
        valid_d     = 1'b1;
        count_d     = dec_bin;
        have_prev_d = 1'b1;
        if (have_prev) begin
          if (is_hold) begin
            good = 1'b0;
          end else if (is_up) begin
            good   = 1'b1;
            wrap_d = (count == CW'(STATES - 1));
`ifdef JOHNSON_DOWN_EN
            dir_d  = 1'b0;
          end else if (is_down) begin
            good   = 1'b1;
            wrap_d = (count == '0);
            dir_d  = 1'b1;
`endif
          end else begin
            bad_d  = 1'b1;
            err_ev = 1'b1;
          end
        end
      end
    end

    if (err_ev) begin
      state_d = SEARCH;
      run_d   = '0;
    end else if (good && (state_q == SEARCH)) begin
      if (run_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
        state_d = LOCKED;
        run_d   = '0;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end

    if (err_clr)                       err_d = err_ev ? ERR_W'(1) : '0;
    else if (err_ev && err_cnt != '1)  err_d = err_cnt + ERR_W'(1);
  end

  // All state and outputs registered; asynchronous clear returns to SEARCH.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      have_prev <= 1'b0;
      count     <= '0;
      valid     <= 1'b0;
      illegal   <= 1'b0;
      bad_step  <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
`ifdef JOHNSON_DOWN_EN
      dir       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      have_prev <= have_prev_d;
      count     <= count_d;
      valid     <= valid_d;
      illegal   <= illegal_d;
      bad_step  <= bad_d;
      wrap      <= wrap_d;
      err_cnt   <= err_d;
`ifdef JOHNSON_DOWN_EN
      dir       <= dir_d;
`endif
    end
  end

  assign locked    = (state_q == LOCKED);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Bench for johnson_decoder_monitor (N=4, LOCK_CNT=4, ERR_W=8).
module tb_johnson_decoder_monitor;
  import johnson_pkg::*;

  localparam int N        = 4;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int NS       = 2 * N;

  typedef struct packed {
    logic [2:0] count;
    logic       valid;
    logic       illegal;
    logic       bad;
    logic       wrap;
    logic       locked;
    logic [7:0] err;
  } obs_t;
  localparam int W = $bits(obs_t);

  typedef struct {
    logic [3:0] q;
    bit         en;
    bit         ec;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] q_in = '0;
  logic       sample_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] count;
  logic       valid, illegal, bad_step, wrap, locked;
  logic [7:0] err_cnt;
  state_t     fsm_state;
`ifdef JOHNSON_DOWN_EN
  logic       dir;
`endif

  johnson_decoder_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .q_in      (q_in),
    .sample_en (sample_en),
    .err_clr   (err_clr),
    .count     (count),
    .valid     (valid),
    .illegal   (illegal),
    .bad_step  (bad_step),
    .wrap      (wrap),
    .locked    (locked),
    .err_cnt   (err_cnt),
`ifdef JOHNSON_DOWN_EN
    .dir       (dir),
`endif
    .fsm_state (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0] codes[NS];

  // reference model state
  bit m_have;
  int m_count;
  int m_run;
  bit m_locked;
  int m_err;
  bit m_dir;

  function automatic obs_t mk(int c, bit v, bit il, bit b, bit w, bit l, int e);
    obs_t o;
    o.count = 3'(c); o.valid = v; o.illegal = il; o.bad = b;
    o.wrap = w; o.locked = l; o.err = 8'(e);
    return o;
  endfunction

  function automatic obs_t get_obs();
    return mk(int'(count), valid, illegal, bad_step, wrap, locked, int'(err_cnt));
  endfunction

  task automatic model_reset();
    m_have = 0; m_count = 0; m_run = 0; m_locked = 0; m_err = 0; m_dir = 0;
  endtask

  // Behavioural model: decode by searching the generated code sequence.
  task automatic model(input logic [3:0] q, input bit en, input bit ec, output obs_t e);
    int dec;
    int delta;
    bit err;
    bit good;
    bit il, b, w, v;
    dec = -1; err = 0; good = 0; il = 0; b = 0; w = 0; v = 0;
    for (int k = 0; k < NS; k++) if (codes[k] == q) dec = k;
    if (en) begin
      if (dec < 0) begin
        il = 1; err = 1; m_have = 0;
      end else begin
        v = 1;
        if (m_have) begin
          delta = (dec - m_count + NS) % NS;
          if (delta == 0) begin
            good = 0;
          end else if (delta == 1) begin
            good = 1; w = (m_count == NS - 1); m_dir = 0;
`ifdef JOHNSON_DOWN_EN
          end else if (delta == NS - 1) begin
            good = 1; w = (m_count == 0); m_dir = 1;
`endif
          end else begin
            b = 1; err = 1;
          end
        end
        m_count = dec;
        m_have = 1;
      end
    end
    if (err) begin
      m_locked = 0; m_run = 0;
    end else if (good && !m_locked) begin
      m_run++;
      if (m_run == LOCK_CNT) begin m_locked = 1; m_run = 0; end
    end
    if (ec) m_err = err ? 1 : 0;
    else if (err && m_err < 255) m_err++;
    e = mk(m_count, v, il, b, w, m_locked, m_err);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d v=%b il=%b bad=%b wr=%b lk=%b err=%0d, required cnt=%0d v=%b il=%b bad=%b wr=%b lk=%b err=%0d",
               name, got.count, got.valid, got.illegal, got.bad, got.wrap, got.locked, got.err,
               want.count, want.valid, want.illegal, want.bad, want.wrap, want.locked, want.err);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic [3:0] q, input bit en, input bit ec, input string name);
    obs_t e;
    @(negedge clk);
    q_in = q; sample_en = en; err_clr = ec;
    model(q, en, ec, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(name, get_obs(), obs_t'(exp_q.pop_front()));
`ifdef JOHNSON_DOWN_EN
    check_bit({name, "_dir"}, dir, m_dir);
`endif
  endtask

  vec_t vecs[19];

  initial begin
    logic [3:0] cq;
    int cur;
    int r;
    logic [3:0] nq;

    cq = '0;
    for (int k = 0; k < NS; k++) begin
      codes[k] = cq;
      cq = {cq[N-2:0], ~cq[N-1]};
    end

    vecs[0]  = '{4'b0000, 1, 0, mk(0, 1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{4'b0001, 1, 0, mk(1, 1, 0, 0, 0, 0, 0)};
    vecs[2]  = '{4'b0011, 1, 0, mk(2, 1, 0, 0, 0, 0, 0)};
    vecs[3]  = '{4'b0111, 1, 0, mk(3, 1, 0, 0, 0, 0, 0)};
    vecs[4]  = '{4'b1111, 1, 0, mk(4, 1, 0, 0, 0, 1, 0)};
    vecs[5]  = '{4'b1110, 1, 0, mk(5, 1, 0, 0, 0, 1, 0)};
    vecs[6]  = '{4'b1100, 1, 0, mk(6, 1, 0, 0, 0, 1, 0)};
    vecs[7]  = '{4'b1000, 1, 0, mk(7, 1, 0, 0, 0, 1, 0)};
    vecs[8]  = '{4'b0000, 1, 0, mk(0, 1, 0, 0, 1, 1, 0)};
    vecs[9]  = '{4'b0101, 1, 0, mk(0, 0, 1, 0, 0, 0, 1)};
    vecs[10] = '{4'b0011, 1, 0, mk(2, 1, 0, 0, 0, 0, 1)};
    vecs[11] = '{4'b0111, 1, 0, mk(3, 1, 0, 0, 0, 0, 1)};
    vecs[12] = '{4'b0001, 1, 0, mk(1, 1, 0, 1, 0, 0, 2)};
    vecs[13] = '{4'b0111, 1, 0, mk(3, 1, 0, 1, 0, 0, 3)};
    vecs[14] = '{4'b0111, 1, 0, mk(3, 1, 0, 0, 0, 0, 3)};
    vecs[15] = '{4'b1111, 1, 0, mk(4, 1, 0, 0, 0, 0, 3)};
    vecs[16] = '{4'b0101, 0, 0, mk(4, 0, 0, 0, 0, 0, 3)};
    vecs[17] = '{4'b0101, 0, 1, mk(4, 0, 0, 0, 0, 0, 0)};
    vecs[18] = '{4'b0101, 1, 1, mk(4, 0, 1, 0, 0, 0, 1)};

    // reset block
    model_reset();
    #1;
    check("reset", get_obs(), mk(0, 0, 0, 0, 0, 0, 0));
    check_bit("reset_state", fsm_state == SEARCH, 1'b1);
    @(negedge clk);
    clr_n = 1'b1;

    // directed table
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].q, vecs[i].en, vecs[i].ec, $sformatf("model%0d", i));
      check($sformatf("tbl%0d", i), get_obs(), vecs[i].exp);
    end

    // saturation then clear with a simultaneous error
    for (int i = 0; i < 260; i++) step(4'b1010, 1, 0, "sat_run");
    vectors++;
    if (err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat: got err=%0d required 255", err_cnt);
    end
    step(4'b0110, 1, 1, "clr_with_err");
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_with_err_val: got err=%0d required 1", err_cnt);
    end

    // lock, then asynchronous reset between edges
    step(4'b0000, 1, 0, "relock0");
    step(4'b0001, 1, 0, "relock1");
    step(4'b0011, 1, 0, "relock2");
    step(4'b0111, 1, 0, "relock3");
    step(4'b1111, 1, 0, "relock4");
    check_bit("relock_locked", locked, 1'b1);
    @(negedge clk);
    sample_en = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", get_obs(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    clr_n = 1'b1;

`ifdef JOHNSON_DOWN_EN
    step(4'b0011, 1, 0, "down_prime");
    step(4'b0001, 1, 0, "down_step");
    check_bit("down_no_bad", bad_step, 1'b0);
    check_bit("down_dir", dir, 1'b1);
    step(4'b0000, 1, 0, "down_to0");
    step(4'b1000, 1, 0, "down_wrap");
    check_bit("down_wrap_pulse", wrap, 1'b1);
`endif

    // randomized stimulus against the model
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      begin cur = (cur + 1) % NS; nq = codes[cur]; end
      else if (r < 75) begin nq = codes[cur]; end
      else if (r < 82) begin cur = (cur + NS - 1) % NS; nq = codes[cur]; end
      else if (r < 90) begin nq = 4'($urandom_range(0, 15)); end
      else             begin cur = $urandom_range(0, NS - 1); nq = codes[cur]; end
      step(nq, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
